// File: rtl/im_stream_fetcher_pkg.sv
// Shared types and defaults for the item-memory stream fetcher.
//   fetch_state_e : fetcher FSM state encoding
//   DefFifoDepth  : default output buffer depth / outstanding-request limit
package im_stream_fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    localparam int unsigned DefFifoDepth = 4;

endpackage

// File: rtl/im_stream_fetcher_fifo_buffer.sv
// Small synchronous FIFO with optional first-word fall-through.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clr_i         : synchronous flush
//   data_i/valid_i: push side (caller guarantees space)
//   data_o/valid_o/ready_i : pop side, valid/ready handshake
//   count_o       : number of stored words
module fifo_buffer #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned FifoDepth   = 4,
    parameter bit          FallThrough = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic [DataWidth-1:0]           data_i,
    input  logic                           valid_i,
    output logic [DataWidth-1:0]           data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [$clog2(FifoDepth+1)-1:0] count_o
);

    localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth-1:0]  wr_ptr;
    logic empty, full, bypass, pop, wr_en, rd_en;

    assign empty   = (count_o == '0);
    assign full    = (count_o == CntWidth'(FifoDepth));
    assign bypass  = FallThrough && empty;
    assign valid_o = !empty || (bypass && valid_i);
    assign data_o  = empty ? data_i : mem[rd_ptr];
    assign pop     = valid_o && ready_i;
    assign rd_en   = pop && !empty;
    // A word that falls straight through to a waiting consumer is never stored.
    assign wr_en   = valid_i && !(bypass && pop) && (!full || rd_en);

    // Storage array, no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
            end
            count_o <= count_o + CntWidth'(wr_en) - CntWidth'(rd_en);
        end
    end

endmodule

// File: rtl/im_stream_fetcher.sv
// Strided memory reader feeding the item memory's low-dim address stream.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cfg_*          : base address, stride, item count (sampled on accepted start)
//   start_i, clr_i : start pulse, abort/flush
//   busy_o, done_o : run status, one-cycle completion pulse
//   mem_req_*      : read request channel (valid/ready)
//   mem_rsp_*      : in-order read response (no backpressure)
//   lowdim_*       : streamed item addresses (valid/ready)
module im_stream_fetcher
    import im_stream_fetcher_pkg::*;
#(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned CountWidth = 16,
    parameter int unsigned FifoDepth  = DefFifoDepth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AddrWidth-1:0]  cfg_base_addr_i,
    input  logic [AddrWidth-1:0]  cfg_stride_i,
    input  logic [CountWidth-1:0] cfg_num_items_i,
    input  logic                  start_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [AddrWidth-1:0]  mem_req_addr_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic [DataWidth-1:0]  mem_rsp_data_i,
    input  logic                  mem_rsp_valid_i,
    output logic [DataWidth-1:0]  lowdim_data_o,
    output logic                  lowdim_valid_o,
    input  logic                  lowdim_ready_i
);

    localparam int unsigned CntWidth = $clog2(FifoDepth + 1);
    localparam int unsigned SumWidth = CntWidth + 1;

    fetch_state_e          state;
    logic [AddrWidth-1:0]  addr;
    logic [AddrWidth-1:0]  stride;
    logic [CountWidth-1:0] remaining;
    logic [CntWidth-1:0]   inflight;
    logic [CntWidth-1:0]   fifo_count;
    logic credit_ok, req_fire, rsp_push, start_ok;

    // Every outstanding request owns a FIFO slot, so responses never overflow.
    assign credit_ok       = (SumWidth'(inflight) + SumWidth'(fifo_count)) < SumWidth'(FifoDepth);
    assign mem_req_valid_o = (state == RUN) && (remaining != '0) && credit_ok;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;
    // Responses outside a run belong to an aborted run and are dropped.
    assign rsp_push        = mem_rsp_valid_i && ((state == RUN) || (state == DRAIN)) && !clr_i;
    assign start_ok        = start_i && (inflight == '0);
    assign mem_req_addr_o  = addr;
    assign busy_o          = (state == RUN) || (state == DRAIN);
    assign done_o          = (state == DONE);

    // Sequencer: address generation, credit accounting and run control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr      <= '0;
            stride    <= '0;
            remaining <= '0;
            inflight  <= '0;
        end else begin
            // Outstanding count survives an abort so late responses are absorbed.
            inflight <= inflight + CntWidth'(req_fire) - CntWidth'(mem_rsp_valid_i);
            if (clr_i) begin
                state     <= IDLE;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            addr      <= cfg_base_addr_i;
                            stride    <= cfg_stride_i;
                            remaining <= cfg_num_items_i;
                            state     <= (cfg_num_items_i == '0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (req_fire) begin
                            addr      <= addr + stride;
                            remaining <= remaining - CountWidth'(1);
                            if (remaining == CountWidth'(1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if ((inflight == '0) && (fifo_count == '0)) begin
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fifo_buffer #(
        .DataWidth  (DataWidth),
        .FifoDepth  (FifoDepth),
        .FallThrough(1'b1)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .data_i (mem_rsp_data_i),
        .valid_i(rsp_push),
        .data_o (lowdim_data_o),
        .valid_o(lowdim_valid_o),
        .ready_i(lowdim_ready_i),
        .count_o(fifo_count)
    );

endmodule

// File: doc/im_stream_fetcher.md
Name: im_stream_fetcher

Overview:
- Upstream feeder for the item memory's port A low-dim input.
- On start, issues a programmed sequence of strided reads to a single in-order memory data port.
- Buffers the returned words in a small FIFO and streams them out over a valid/ready handshake as low-dim item addresses.
- Credit-based issue guarantees that every response has buffer space, so no response is ever dropped or back-pressured.

Parameters:
AddrWidth, 32, memory address width.
DataWidth, 32, response word width; equals the item memory's low-dim address width.
CountWidth, 16, width of the item-count configuration.
FifoDepth, 4, output buffer depth; also the maximum number of outstanding requests (≥2).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
cfg_base_addr_i  in  AddrWidth  address of first item
cfg_stride_i  in  AddrWidth  byte increment between items
cfg_num_items_i  in  CountWidth  number of items to fetch
start_i  in  1  single-cycle start pulse
clr_i  in  1  synchronous software abort/flush
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle completion pulse
mem_req_addr_o  out  AddrWidth  read address
mem_req_valid_o  out  1  read request valid
mem_req_ready_i  in  1  memory accepts request
mem_rsp_data_i  in  DataWidth  read data
mem_rsp_valid_i  in  1  read data valid; in order, ≥1 cycle after acceptance
lowdim_data_o  out  DataWidth  streamed item address
lowdim_valid_o  out  1  output valid
lowdim_ready_i  in  1  consumer ready

Behaviour:
- Reset (rst_i high at a clock edge):
  - State IDLE.
  - busy_o, done_o, mem_req_valid_o and lowdim_valid_o are 0; mem_req_addr_o is 0.
  - Counters are 0 and the FIFO is empty.
- Configuration inputs are sampled only on an accepted start. Changes during a run have no effect.
- FSM states:
  - IDLE: a start is accepted when start_i=1 and inflight=0.
    - Latch the address to base, remaining to num_items, issued to 0.
    - If num_items=0, go to DONE. Otherwise go to RUN.
    - start_i while not in IDLE, or while inflight>0, is ignored.
  - RUN: mem_req_valid_o = (remaining>0) && (inflight + fifo_count < FifoDepth).
    - On req handshake: addr += stride (modulo 2^AddrWidth, wrap silently), remaining -= 1, inflight += 1.
    - When remaining reaches 0, go to DRAIN.
    - mem_req_valid_o may drop only when credits run out. Once asserted, mem_req_addr_o is held stable until accepted.
  - DRAIN: no requests. Go to DONE when inflight=0 and the FIFO is empty (the last item has been consumed).
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
  - busy_o=1 in RUN and DRAIN.
- Response path:
  - Each mem_rsp_valid_i pushes mem_rsp_data_i into the FIFO and decrements inflight. A simultaneous request accept and response nets inflight to unchanged.
  - The FIFO is first-word fall-through: lowdim_valid_o rises in the same cycle as the response when the FIFO is empty.
  - Pop on lowdim_valid_o && lowdim_ready_i. Push and pop in the same cycle keep the count unchanged.
  - The credit rule makes an overflow push impossible. The bench asserts this.
- lowdim_valid_o, once asserted, stays high with stable data until the pop handshake.
- Output order equals request order.
- clr_i:
  - Forces IDLE next cycle, flushes the FIFO, deasserts mem_req_valid_o, and clears remaining.
  - No done_o pulse.
  - inflight is kept. Responses arriving afterwards decrement inflight but are discarded, not pushed.
  - New starts are blocked until inflight=0.
- rst_i takes priority over clr_i. clr_i takes priority over start_i in the same cycle.
- Width rules:
  - inflight and fifo_count are clog2(FifoDepth+1) bits.
  - remaining is CountWidth bits.
  - Address arithmetic is AddrWidth-bit unsigned.

Decomposition:
- Shared package (hypercorex pkg):
  - fetcher state enum typedef (IDLE, RUN, DRAIN, DONE).
  - Default FifoDepth constant.
- Sub-module: reuse the existing fifo_buffer with FallThrough=1, DataWidth=DataWidth, FifoDepth=FifoDepth. Its counter output supplies fifo_count and clr_i drives its clear.
- Address, credit and FSM logic stay in this module.

Test Plan:
- Basic run: base=0x100, stride=4, n=3, memory always ready with 1-cycle latency, consumer always ready → addresses 0x100, 0x104, 0x108 are issued; outputs are the read data in order; done_o pulses once after the third pop.
- Backpressure: n=8, FifoDepth=4, lowdim_ready_i=0 → exactly 4 requests issued, then mem_req_valid_o=0. Then lowdim_ready_i=1 → the remaining 4 issue and all 8 arrive in order.
- Zero count: n=0 with start → no request; done_o=1 exactly one cycle after start; busy_o stays 0.
- Address wrap: base=0xFFFF_FFF8, stride=8, n=2 → addresses 0xFFFF_FFF8, then 0x0000_0000.
- Abort: clr_i with 2 requests in flight → FIFO is empty next cycle; the 2 late responses never appear on lowdim_valid_o; a start issued before they return is ignored; a start after they return is accepted.
- Random stalls: random mem_req_ready_i, response latency of 1–5 cycles, random lowdim_ready_i, n=100 → output sequence equals the reference model; no overflow assertion fires; done_o occurs exactly once.
